// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM register, req/ack data-memory access with timeout, MEM/WB drive.
// state | meaning:  IDLE idle or first request cycle | BUSY waiting for ack | DONE result valid, one cycle
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemtoRegE,
    input  logic        MemWriteE,
    input  logic [31:0] ALUOutE,
    input  logic [31:0] WriteDataE,
    input  logic [4:0]  WriteRegE,
    input  logic        ValidE,
    output logic        StallM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic [31:0] ReadDataM,
    output logic [31:0] ALUOutM,
    output logic [4:0]  WriteRegM,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic               regwrite_q, regwrite_d;
    logic               memtoreg_q, memtoreg_d;
    logic               memwrite_q, memwrite_d;
    logic               valid_q, valid_d;
    logic [31:0]        aluout_q, aluout_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [4:0]         wreg_q, wreg_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;
    logic               misalign_err_q, misalign_err_d;
    logic               bus_err_q, bus_err_d;

    logic aligned, mem_instr, mem_op, misaligned_mem, stall;

    always_comb begin
        aligned        = (aluout_q[1:0] == 2'b00);
        mem_instr      = valid_q & (memtoreg_q | memwrite_q);
        mem_op         = mem_instr & aligned;
        misaligned_mem = mem_instr & ~aligned;
        stall          = mem_op & (state_q != DONE);

        regwrite_d     = regwrite_q;
        memtoreg_d     = memtoreg_q;
        memwrite_d     = memwrite_q;
        valid_d        = valid_q;
        aluout_d       = aluout_q;
        wdata_d        = wdata_q;
        wreg_d         = wreg_q;
        state_d        = state_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        abort_d        = abort_q;
        misalign_err_d = misalign_err_q | misaligned_mem;
        bus_err_d      = bus_err_q;

        if (!stall) begin
            regwrite_d = RegWriteE;
            memtoreg_d = MemtoRegE;
            memwrite_d = MemWriteE;
            valid_d    = ValidE;
            aluout_d   = ALUOutE;
            wdata_d    = WriteDataE;
            wreg_d     = WriteRegE;
        end

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    if (mem_ack) begin
                        state_d = DONE;
                        if (memtoreg_q) rdata_d = mem_rdata;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack takes priority over a coinciding terminal count.
                if (mem_ack) begin
                    state_d = DONE;
                    if (memtoreg_q) rdata_d = mem_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    rdata_d   = 32'd0;
                    bus_err_d = 1'b1;
                    abort_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                abort_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                abort_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            memwrite_q     <= 1'b0;
            valid_q        <= 1'b0;
            aluout_q       <= 32'd0;
            wdata_q        <= 32'd0;
            wreg_q         <= 5'd0;
            rdata_q        <= 32'd0;
            cnt_q          <= '0;
            abort_q        <= 1'b0;
            misalign_err_q <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            regwrite_q     <= regwrite_d;
            memtoreg_q     <= memtoreg_d;
            memwrite_q     <= memwrite_d;
            valid_q        <= valid_d;
            aluout_q       <= aluout_d;
            wdata_q        <= wdata_d;
            wreg_q         <= wreg_d;
            rdata_q        <= rdata_d;
            cnt_q          <= cnt_d;
            abort_q        <= abort_d;
            misalign_err_q <= misalign_err_d;
            bus_err_q      <= bus_err_d;
        end
    end

    assign StallM       = stall;
    assign mem_req      = stall;
    assign mem_we       = memwrite_q;
    assign mem_addr     = aluout_q;
    assign mem_wdata    = wdata_q;
    assign RegWriteM    = valid_q & regwrite_q & ~stall & ~abort_q & ~misaligned_mem;
    assign MemtoRegM    = valid_q & memtoreg_q & ~stall;
    assign ReadDataM    = rdata_q;
    assign ALUOutM      = aluout_q;
    assign WriteRegM    = wreg_q;
    assign misalign_err = misalign_err_q;
    assign bus_err      = bus_err_q;

endmodule
